// File: rtl/note_scheduler.sv
// Round sequencer for the three-lane falling-note game: chart stepping, note scroll, hit judging.
// Optional MISS_PENALTY_EN: invalid button hits during a round cost the active player one point.
module note_scheduler #(
    parameter int unsigned TICK_DIV       = 2097152,
    parameter int unsigned STEPS_PER_BEAT = 64,
    parameter int unsigned CHART_LEN      = 8,
    parameter int unsigned HIT_Y          = 400,
    parameter int unsigned HIT_WIN        = 10,
    parameter int unsigned WIN_SCORE      = 10
) (
    input  logic        board_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  btn_hit,
    output logic [3:0]  chart_addr,
    input  logic [2:0]  chart_data,
    output logic [2:0]  note_active,
    output logic [29:0] note_pos,
    output logic [3:0]  p1_score,
    output logic [3:0]  p2_score,
    output logic [1:0]  state
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (STEPS_PER_BEAT > 1) ? $clog2(STEPS_PER_BEAT) : 1;

    localparam logic [TW-1:0] TickLast  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] StepLast  = SW'(STEPS_PER_BEAT - 1);
    localparam logic [3:0]    ChartLast = 4'(CHART_LEN - 1);
    localparam logic [3:0]    WinScore  = 4'(WIN_SCORE);
    localparam logic [9:0]    WinLo     = 10'(HIT_Y - HIT_WIN);
    localparam logic [9:0]    WinHi     = 10'(HIT_Y + HIT_WIN);

    typedef enum logic [1:0] {
        StQi    = 2'b00,
        StGame1 = 2'b01,
        StGame2 = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [SW-1:0]    step_q, step_d;
    logic [3:0]       addr_q, addr_d;
    logic             drain_q, drain_d;
    logic [2:0]       act_q, act_d;
    logic [2:0][9:0]  pos_q, pos_d;
    logic [3:0]       p1_q, p1_d;
    logic [3:0]       p2_q, p2_d;
    logic [2:0]       btn_s1_q, btn_s2_q, btn_s3_q;

    logic       in_game, tick, spawn, round_end;
    logic [2:0] hit, valid;
    logic [1:0] n_valid;
    logic [3:0] cur_score, new_score;
    logic [4:0] raised, lowered;
`ifdef MISS_PENALTY_EN
    logic [2:0] invalid;
    logic [1:0] n_invalid;
`endif

    assign in_game = (state_q == StGame1) || (state_q == StGame2);
    assign tick    = in_game && (tick_q == TickLast);
    assign spawn   = tick && (step_q == '0) && !drain_q;
    assign hit     = btn_s2_q & ~btn_s3_q & {3{in_game}};

    assign round_end = (drain_q && (act_q == 3'b000)) ||
                       ((state_q == StGame1) && (p1_q == WinScore)) ||
                       ((state_q == StGame2) && (p2_q == WinScore));

    always_comb begin
        valid = 3'b000;
        for (int l = 0; l < 3; l++) begin
            valid[l] = hit[l] && act_q[l] && (pos_q[l] >= WinLo) && (pos_q[l] <= WinHi);
        end
    end

    assign n_valid   = {1'b0, valid[0]} + {1'b0, valid[1]} + {1'b0, valid[2]};
    assign cur_score = (state_q == StGame2) ? p2_q : p1_q;
    assign raised    = {1'b0, cur_score} + {3'b000, n_valid};

`ifdef MISS_PENALTY_EN
    assign invalid   = hit & ~valid;
    assign n_invalid = {1'b0, invalid[0]} + {1'b0, invalid[1]} + {1'b0, invalid[2]};
    assign lowered   = (raised < {3'b000, n_invalid}) ? 5'd0 : raised - {3'b000, n_invalid};
`else
    assign lowered   = raised;
`endif

    assign new_score = (lowered > {1'b0, WinScore}) ? WinScore : lowered[3:0];

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        step_d  = step_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        act_d   = act_q;
        pos_d   = pos_q;
        p1_d    = p1_q;
        p2_d    = p2_q;

        unique case (state_q)
            StQi: begin
                tick_d = '0;
                if (start) begin
                    state_d = StGame1;
                    p1_d    = '0;
                    p2_d    = '0;
                    act_d   = '0;
                    pos_d   = '0;
                    addr_d  = '0;
                    step_d  = '0;
                    drain_d = 1'b0;
                end
            end
            StGame1, StGame2: begin
                if (!start || round_end) begin
                    tick_d  = '0;
                    step_d  = '0;
                    addr_d  = '0;
                    drain_d = 1'b0;
                    act_d   = '0;
                    pos_d   = '0;
                    if (!start) begin
                        state_d = StQi;
                    end else begin
                        state_d = (state_q == StGame1) ? StGame2 : StDone;
                    end
                end else begin
                    tick_d = tick ? '0 : tick_q + TW'(1);
                    // Order matters: scroll/miss, then hit clears, then spawn overrides.
                    for (int l = 0; l < 3; l++) begin
                        if (tick && act_q[l]) begin
                            if (pos_q[l] == WinHi) act_d[l] = 1'b0;
                            else                   pos_d[l] = pos_q[l] + 10'd1;
                        end
                        if (valid[l]) act_d[l] = 1'b0;
                        if (spawn && chart_data[l]) begin
                            act_d[l] = 1'b1;
                            pos_d[l] = '0;
                        end
                    end
                    if (spawn) begin
                        if (addr_q == ChartLast) drain_d = 1'b1;
                        else                     addr_d  = addr_q + 4'd1;
                    end
                    if (tick) begin
                        step_d = (step_q == StepLast) ? '0 : step_q + SW'(1);
                    end
                    if (state_q == StGame1) p1_d = new_score;
                    else                    p2_d = new_score;
                end
            end
            StDone: begin
                tick_d = '0;
                if (!start) state_d = StQi;
            end
            default: state_d = StQi;
        endcase
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q  <= StQi;
            tick_q   <= '0;
            step_q   <= '0;
            addr_q   <= '0;
            drain_q  <= 1'b0;
            act_q    <= '0;
            pos_q    <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            btn_s3_q <= '0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            step_q   <= step_d;
            addr_q   <= addr_d;
            drain_q  <= drain_d;
            act_q    <= act_d;
            pos_q    <= pos_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            btn_s1_q <= btn_hit;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
        end
    end

    assign chart_addr  = addr_q;
    assign note_active = act_q;
    assign note_pos    = pos_q;
    assign p1_score    = p1_q;
    assign p2_score    = p2_q;
    assign state       = state_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler with a small chart {R, G+B}: a no-hit timeline table, then a
// scoreboarded sequence of button presses through both rounds, QDONE, restart and async reset.
module tb_note_scheduler;

    logic        board_clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  btn_hit = 3'b000;
    logic [3:0]  chart_addr;
    logic [2:0]  chart_data;
    logic [2:0]  note_active;
    logic [29:0] note_pos;
    logic [3:0]  p1_score, p2_score;
    logic [1:0]  state;

`ifdef MISS_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif
    localparam int P2A = PEN ? 0 : 1;  // p2 after presses on an empty lane
    localparam int P2F = PEN ? 1 : 2;  // p2 at the end of round 2

    note_scheduler #(
        .TICK_DIV(4), .STEPS_PER_BEAT(8), .CHART_LEN(2),
        .HIT_Y(20), .HIT_WIN(2), .WIN_SCORE(3)
    ) dut (
        .board_clk(board_clk), .reset(reset), .start(start), .btn_hit(btn_hit),
        .chart_addr(chart_addr), .chart_data(chart_data), .note_active(note_active),
        .note_pos(note_pos), .p1_score(p1_score), .p2_score(p2_score), .state(state)
    );

    assign chart_data = (chart_addr == 4'd0) ? 3'b100 : 3'b011;

    always #5 board_clk = ~board_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        int due; string name; int st; int p1; int p2; int mask; int act;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int cyc; bit start; int st; int act; int addr; int rp; int gp; int bp;
    } vec_t;
    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check({e.name, " due"}, cyc, e.due);
            check({e.name, " state"}, 32'(state), e.st);
            check({e.name, " p1"}, 32'(p1_score), e.p1);
            check({e.name, " p2"}, 32'(p2_score), e.p2);
            check({e.name, " lanes"}, 32'(note_active & 3'(e.mask)), e.act);
        end
    endtask

    task automatic step();
        @(posedge board_clk);
        #1;
        cyc++;
        sb_check();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic press(input logic [2:0] lanes, input string name, input int st,
                         input int p1, input int p2, input int mask, input int act);
        exp_t e;
        e.due = cyc + 3; e.name = name; e.st = st; e.p1 = p1; e.p2 = p2;
        e.mask = mask; e.act = act;
        sb.push_back(e);
        btn_hit = lanes;
        run_to(cyc + 2);
        btn_hit = 3'b000;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " state"}, 32'(state), 0);
        check({tag, " active"}, 32'(note_active), 0);
        check({tag, " pos"}, note_pos, 0);
        check({tag, " p1"}, 32'(p1_score), 0);
        check({tag, " p2"}, 32'(p2_score), 0);
        check({tag, " addr"}, 32'(chart_addr), 0);
    endtask

    task automatic do_reset();
        start = 1'b0;
        btn_hit = 3'b000;
        reset = 1'b1;
        #1;
        check_zero("reset");
        repeat (2) @(posedge board_clk);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // cyc, start, state, active, addr(-1 = skip), R/G/B pos (checked on active lanes)
        tbl[0]  = '{1,   1, 1, 3'b000, 0,  0,  0,  0};
        tbl[1]  = '{4,   1, 1, 3'b000, 0,  0,  0,  0};
        tbl[2]  = '{5,   1, 1, 3'b100, 1,  0,  0,  0};
        tbl[3]  = '{9,   1, 1, 3'b100, 1,  1,  0,  0};
        tbl[4]  = '{33,  1, 1, 3'b100, 1,  7,  0,  0};
        tbl[5]  = '{37,  1, 1, 3'b111, 1,  8,  0,  0};
        tbl[6]  = '{69,  1, 1, 3'b111, 1,  16, 8,  8};
        tbl[7]  = '{93,  1, 1, 3'b111, 1,  22, 14, 14};
        tbl[8]  = '{97,  1, 1, 3'b011, 1,  0,  15, 15};
        tbl[9]  = '{125, 1, 1, 3'b011, 1,  0,  22, 22};
        tbl[10] = '{129, 1, 1, 3'b000, 1,  0,  0,  0};
        tbl[11] = '{130, 1, 2, 3'b000, 0,  0,  0,  0};
        tbl[12] = '{134, 1, 2, 3'b100, 1,  0,  0,  0};
        tbl[13] = '{258, 1, 2, 3'b000, 1,  0,  0,  0};
        tbl[14] = '{262, 0, 3, 3'b000, -1, 0,  0,  0};
        tbl[15] = '{263, 0, 0, 3'b000, -1, 0,  0,  0};

        #3;
        do_reset();

        // Timeline with no buttons pressed.
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            string t;
            run_to(tbl[i].cyc);
            t = $sformatf("tl@%0d", tbl[i].cyc);
            check({t, " state"}, 32'(state), tbl[i].st);
            check({t, " active"}, 32'(note_active), tbl[i].act);
            if (tbl[i].addr >= 0) check({t, " addr"}, 32'(chart_addr), tbl[i].addr);
            if (tbl[i].act[2]) check({t, " rpos"}, 32'(note_pos[29:20]), tbl[i].rp);
            if (tbl[i].act[1]) check({t, " gpos"}, 32'(note_pos[19:10]), tbl[i].gp);
            if (tbl[i].act[0]) check({t, " bpos"}, 32'(note_pos[9:0]), tbl[i].bp);
            check({t, " p1"}, 32'(p1_score), 0);
            check({t, " p2"}, 32'(p2_score), 0);
            start = tbl[i].start;
        end

        // Scored game: round 1 to p1=3, round 2 with empty-lane presses.
        do_reset();
        start = 1'b1;
        run_to(72);  press(3'b100, "r_early",   1, 0, 0,   3'b100, 3'b100);
        run_to(80);  press(3'b100, "r_valid",   1, 1, 0,   3'b100, 3'b000);
        run_to(116); press(3'b011, "gb_pair",   1, 3, 0,   3'b111, 3'b000);
        run_to(120);
        check("round1 end state", 32'(state), 2);
        check("round1 end p1", 32'(p1_score), 3);
        run_to(199); press(3'b100, "r2_valid",  2, 3, 1,   3'b111, 3'b011);
        run_to(207); press(3'b100, "r2_empty1", 2, 3, P2A, 3'b100, 3'b000);
        run_to(215); press(3'b100, "r2_empty2", 2, 3, P2A, 3'b100, 3'b000);
        run_to(245); press(3'b001, "b2_on_tick", 2, 3, P2F, 3'b111, 3'b000);
        run_to(249);
        check("round2 end state", 32'(state), 3);
        run_to(252); press(3'b100, "done_hit",  3, 3, P2F, 3'b000, 3'b000);
        run_to(256);
        start = 1'b0;
        run_to(257);
        check("qi state", 32'(state), 0);
        check("qi p1 held", 32'(p1_score), 3);
        check("qi p2 held", 32'(p2_score), P2F);
        start = 1'b1;
        run_to(258);
        check("restart state", 32'(state), 1);
        check("restart p1", 32'(p1_score), 0);
        check("restart p2", 32'(p2_score), 0);
        run_to(290);
        check("mid active", 32'(note_active), 3'b100);
        check("mid rpos", 32'(note_pos[29:20]), 7);
        check("mid addr", 32'(chart_addr), 1);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async reset");
        check("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
